alu_decode: RTL and testbench

Registered decode stage sitting directly upstream of the RV32 ALU. It accepts RV32I instruction words with PC and register-file operands over a valid/ready handshake. It drives the ALU's control and operand inputs (op, op2, x, y) plus writeback and branch qualifiers from a pipeline register. A skid buffer gives full throughput with a registered upstream ready.

---
 rtl/alu_decode.sv | 185 ++++++++++++++++++
 tb/tb_alu_decode.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_decode.sv
// alu_decode: registered RV32I decode stage feeding the ALU.
// Decodes an instruction word plus PC/register operands into ALU control,
// operands and writeback/branch qualifiers. An output register backed by a
// skid register sustains one beat per cycle with a registered o_in_ready.
// Optional feature macro: ALU_DECODE_ILLEGAL_EN (flags unsupported encodings
// on o_illegal and turns them into NOPs). Undefined: o_illegal is always 0.
module alu_decode (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_val,
  input  logic [31:0] i_rs2_val,
  output logic        o_valid,
  input  logic        i_out_ready,
  output logic [2:0]  o_op,
  output logic        o_op2,
  output logic [31:0] o_x,
  output logic [31:0] o_y,
  output logic [4:0]  o_rd,
  output logic        o_wb,
  output logic        o_branch,
  output logic        o_br_inv,
  output logic        o_illegal
);

`ifdef ALU_DECODE_ILLEGAL_EN
  localparam logic ILLEGAL_EN = 1'b1;
`else
  localparam logic ILLEGAL_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  op;
    logic        op2;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
    logic        wb;
    logic        branch;
    logic        br_inv;
    logic        illegal;
  } dec_t;

  dec_t        dec;
  dec_t        out_q;
  dec_t        skid_q;
  logic        out_valid;
  logic        skid_valid;
  logic        accept;
  logic        ill;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;

  assign opcode = i_instr[6:0];
  assign f3     = i_instr[14:12];
  assign f7     = i_instr[31:25];
  assign imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_u  = {i_instr[31:12], 12'b0};

  // Instruction decode; rd is only reported for writeback-type instructions.
  always_comb begin
    dec = '0;
    ill = 1'b0;
    unique case (opcode)
      7'b0110011: begin
        dec.op  = f3;
        dec.op2 = (f3 == 3'b000 || f3 == 3'b101) ? i_instr[30] : 1'b0;
        dec.x   = i_rs1_val;
        dec.y   = i_rs2_val;
        dec.rd  = i_instr[11:7];
        dec.wb  = 1'b1;
        ill     = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
      end
      7'b0010011: begin
        dec.op  = f3;
        dec.op2 = (f3 == 3'b101) ? i_instr[30] : 1'b0;
        dec.x   = i_rs1_val;
        dec.y   = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, i_instr[24:20]} : imm_i;
        dec.rd  = i_instr[11:7];
        dec.wb  = 1'b1;
        ill     = (f3 == 3'b001 && f7 != 7'h00) ||
                  (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      7'b0110111: begin
        dec.y  = imm_u;
        dec.rd = i_instr[11:7];
        dec.wb = 1'b1;
      end
      7'b0010111: begin
        dec.x  = i_pc;
        dec.y  = imm_u;
        dec.rd = i_instr[11:7];
        dec.wb = 1'b1;
      end
      7'b1101111, 7'b1100111: begin
        dec.x  = i_pc;
        dec.y  = 32'd4;
        dec.rd = i_instr[11:7];
        dec.wb = 1'b1;
        ill    = (opcode == 7'b1100111) && (f3 != 3'b000);
      end
      7'b0000011: begin
        dec.x  = i_rs1_val;
        dec.y  = imm_i;
        dec.rd = i_instr[11:7];
        dec.wb = 1'b1;
        ill    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      7'b0100011: begin
        dec.x = i_rs1_val;
        dec.y = imm_s;
        ill   = (f3 > 3'b010);
      end
      7'b1100011: begin
        dec.x      = i_rs1_val;
        dec.y      = i_rs2_val;
        dec.branch = 1'b1;
        dec.br_inv = f3[0];
        unique case (f3[2:1])
          2'b10:   dec.op = 3'b010;
          2'b11:   dec.op = 3'b011;
          2'b01: begin
            dec.op2 = 1'b1;
            ill     = 1'b1;
          end
          default: dec.op2 = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    dec.wb = dec.wb & (|dec.rd);
    if (ILLEGAL_EN && ill) begin
      dec = '0;
    end
    dec.illegal = ILLEGAL_EN & ill;
  end

  assign accept     = i_valid & ~skid_valid;
  assign o_in_ready = ~skid_valid;

  // Output + skid registers: output refills from skid first, then from input.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || i_out_ready) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign o_valid   = out_valid;
  assign o_op      = out_q.op;
  assign o_op2     = out_q.op2;
  assign o_x       = out_q.x;
  assign o_y       = out_q.y;
  assign o_rd      = out_q.rd;
  assign o_wb      = out_q.wb;
  assign o_branch  = out_q.branch;
  assign o_br_inv  = out_q.br_inv;
  assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_decode.sv
// tb_alu_decode: directed scoreboard bench for alu_decode.
module tb_alu_decode;

`ifdef ALU_DECODE_ILLEGAL_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_in_ready;
  logic [31:0] i_instr = '0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_rs1_val = '0;
  logic [31:0] i_rs2_val = '0;
  logic        o_valid;
  logic        i_out_ready = 1'b1;
  logic [2:0]  o_op;
  logic        o_op2;
  logic [31:0] o_x;
  logic [31:0] o_y;
  logic [4:0]  o_rd;
  logic        o_wb;
  logic        o_branch;
  logic        o_br_inv;
  logic        o_illegal;

  typedef struct packed {
    logic [2:0]  op;
    logic        op2;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
    logic        wb;
    logic        branch;
    logic        br_inv;
    logic        illegal;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  exp_t        e;
  logic [76:0] got;
  int          n_tests = 0;
  int          n_fail = 0;

  alu_decode dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_in_ready(o_in_ready),
    .i_instr(i_instr), .i_pc(i_pc), .i_rs1_val(i_rs1_val), .i_rs2_val(i_rs2_val),
    .o_valid(o_valid), .i_out_ready(i_out_ready), .o_op(o_op), .o_op2(o_op2),
    .o_x(o_x), .o_y(o_y), .o_rd(o_rd), .o_wb(o_wb), .o_branch(o_branch),
    .o_br_inv(o_br_inv), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  assign got = {o_op, o_op2, o_x, o_y, o_rd, o_wb, o_branch, o_br_inv, o_illegal};

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic exp_t mk(logic [2:0] op, logic op2, logic [31:0] x, logic [31:0] y,
                              logic [4:0] rd, logic wb, logic br, logic inv, logic il);
    exp_t r;
    r = '{op: op, op2: op2, x: x, y: y, rd: rd, wb: wb, branch: br, br_inv: inv, illegal: il};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [76:0] g, input logic [76:0] x);
    n_tests++;
    assert (g === x) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, g, x);
    end
  endtask

  // One clock: record accepts/consumes just before the edge, then step past it.
  task automatic tick();
    logic acc;
    @(negedge clk);
    acc = i_valid && o_in_ready;
    if (acc) q.push_back(cur);
    if (o_valid && i_out_ready) begin
      n_tests++;
      assert (q.size() > 0) else begin
        n_fail++;
        $error("FAIL sb_underflow observed=%h expected=none", got);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_beat", got, e);
      end
    end
    @(posedge clk);
    #1;
    if (acc) i_valid = 1'b0;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input exp_t x);
    i_instr = ins; i_pc = pc; i_rs1_val = a; i_rs2_val = b; cur = x; i_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input exp_t x);
    offer(ins, pc, a, b, x);
    for (int k = 0; k < 20 && i_valid; k++) tick();
    if (i_valid) begin
      chk("send_timeout", 77'(i_valid), 77'(0));
      i_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 30 && (q.size() > 0 || i_valid || o_valid); k++) tick();
    chk("drain_empty", 77'(q.size()), 77'(0));
  endtask

  initial begin
    #1;
    chk("rst_valid", 77'(o_valid), 77'(0));
    chk("rst_ready", 77'(o_in_ready), 77'(1));
    chk("rst_fields", got, 77'(0));
    #11 rst = 1'b0;
    @(posedge clk); #1;

    // ADD x3,x1,x2 : one-cycle latency
    send(32'h002081B3, 32'h100, 32'd5, 32'd7, mk(3'b000, 0, 32'd5, 32'd7, 5'd3, 1, 0, 0, 0));
    chk("add_latency_valid", 77'(o_valid), 77'(1));
    chk("add_fields", got, mk(3'b000, 0, 32'd5, 32'd7, 5'd3, 1, 0, 0, 0));

    // SUB then SRAI back-to-back
    send(32'h402081B3, 32'h104, 32'd9, 32'd4, mk(3'b000, 1, 32'd9, 32'd4, 5'd3, 1, 0, 0, 0));
    chk("b2b_ready", 77'(o_in_ready), 77'(1));
    send(32'h40335293, 32'h108, 32'h80000000, 32'd0,
         mk(3'b101, 1, 32'h80000000, 32'd3, 5'd5, 1, 0, 0, 0));
    chk("b2b_ready2", 77'(o_in_ready), 77'(1));

    // BNE, LUI, ADDI negative, AUIPC, JAL, SW, ADD x0, BGEU, LW negative
    send(32'h00209463, 32'h10C, 32'd1, 32'd2, mk(3'b000, 1, 32'd1, 32'd2, 5'd0, 0, 1, 1, 0));
    send(32'h123450B7, 32'h110, 32'd55, 32'd66, mk(3'b000, 0, 32'd0, 32'h12345000, 5'd1, 1, 0, 0, 0));
    send(32'hFFF08213, 32'h114, 32'd10, 32'd0, mk(3'b000, 0, 32'd10, 32'hFFFFFFFF, 5'd4, 1, 0, 0, 0));
    send(32'h00001117, 32'h2000, 32'd3, 32'd3, mk(3'b000, 0, 32'h2000, 32'h1000, 5'd2, 1, 0, 0, 0));
    send(32'h008000EF, 32'h3000, 32'd3, 32'd3, mk(3'b000, 0, 32'h3000, 32'd4, 5'd1, 1, 0, 0, 0));
    send(32'h0020A223, 32'h120, 32'h400, 32'd9, mk(3'b000, 0, 32'h400, 32'd4, 5'd0, 0, 0, 0, 0));
    send(32'h00208033, 32'h124, 32'd1, 32'd1, mk(3'b000, 0, 32'd1, 32'd1, 5'd0, 0, 0, 0, 0));
    send(32'h0020F063, 32'h128, 32'd8, 32'd9, mk(3'b011, 0, 32'd8, 32'd9, 5'd0, 0, 1, 1, 0));
    send(32'hFF80A283, 32'h12C, 32'h1000, 32'd0, mk(3'b000, 0, 32'h1000, 32'hFFFFFFF8, 5'd5, 1, 0, 0, 0));
    send(32'hFFFFFFFF, 32'h130, 32'd7, 32'd7, mk(3'b000, 0, 32'd0, 32'd0, 5'd0, 0, 0, 0, ILL));
    drain();

    // Downstream stall: output holds A, skid holds B, C waits
    i_out_ready = 1'b0;
    send(32'h002081B3, 32'h200, 32'hA, 32'd1, mk(3'b000, 0, 32'hA, 32'd1, 5'd3, 1, 0, 0, 0));
    chk("stall_a_ready", 77'(o_in_ready), 77'(1));
    send(32'h002081B3, 32'h204, 32'hB, 32'd2, mk(3'b000, 0, 32'hB, 32'd2, 5'd3, 1, 0, 0, 0));
    chk("stall_skid_ready", 77'(o_in_ready), 77'(0));
    chk("stall_hold_x", 77'(o_x), 77'(32'hA));
    offer(32'h002081B3, 32'h208, 32'hC, 32'd3, mk(3'b000, 0, 32'hC, 32'd3, 5'd3, 1, 0, 0, 0));
    tick();
    tick();
    chk("stall_valid", 77'(o_valid), 77'(1));
    chk("stall_hold_fields", got, mk(3'b000, 0, 32'hA, 32'd1, 5'd3, 1, 0, 0, 0));
    chk("stall_c_waiting", 77'(i_valid), 77'(1));
    i_out_ready = 1'b1;
    drain();

    // Asynchronous reset with output and skid full
    i_out_ready = 1'b0;
    send(32'h402081B3, 32'h300, 32'h11, 32'h22, mk(3'b000, 1, 32'h11, 32'h22, 5'd3, 1, 0, 0, 0));
    send(32'h00209463, 32'h304, 32'h33, 32'h44, mk(3'b000, 1, 32'h33, 32'h44, 5'd0, 0, 1, 1, 0));
    chk("prerst_ready", 77'(o_in_ready), 77'(0));
    #3 rst = 1'b1;
    #1;
    chk("midrst_valid", 77'(o_valid), 77'(0));
    chk("midrst_ready", 77'(o_in_ready), 77'(1));
    chk("midrst_fields", got, 77'(0));
    q.delete();
    i_valid = 1'b0;
    #1 rst = 1'b0;
    i_out_ready = 1'b1;
    tick();
    chk("postrst_valid", 77'(o_valid), 77'(0));
    send(32'h123450B7, 32'h400, 32'd0, 32'd0, mk(3'b000, 0, 32'd0, 32'h12345000, 5'd1, 1, 0, 0, 0));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
